// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO, with a busy/tnew countdown for the stall controller.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (ops 5-8); otherwise they are treated as none.
module mdu_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cancel,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [3:0]  tnew,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;

  logic [3:0]  count;
  logic [3:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        op_legal;
  logic        accept;
  logic        is_div;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_div;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [31:0] q_abs;
  logic [31:0] r_abs;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [63:0] result;
  logic        result_we;

  assign busy = (count != 4'd0);
  assign tnew = count;

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO: op_legal = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  end

  assign accept = start & ~cancel & ~busy & op_legal;
  assign is_div = (op == OP_DIV) || (op == OP_DIVU);

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes; this also yields 0x80000000 / -1 = 0x80000000 rem 0.
  assign b_div  = (b_q == 32'd0) ? 32'd1 : b_q;
  assign a_abs  = a_q[31] ? (32'd0 - a_q) : a_q;
  assign b_abs  = b_div[31] ? (32'd0 - b_div) : b_div;
  assign q_abs  = a_abs / b_abs;
  assign r_abs  = a_abs % b_abs;
  assign quot_s = (a_q[31] ^ b_div[31]) ? (32'd0 - q_abs) : q_abs;
  assign rem_s  = a_q[31] ? (32'd0 - r_abs) : r_abs;

  always_comb begin
    result    = 64'd0;
    result_we = 1'b0;
    case (op_q)
      OP_MULT:  begin result = prod_s; result_we = 1'b1; end
      OP_MULTU: begin result = prod_u; result_we = 1'b1; end
      OP_DIV:   begin result = {rem_s, quot_s}; result_we = (b_q != 32'd0); end
      OP_DIVU:  begin result = {a_q % b_div, a_q / b_div}; result_we = (b_q != 32'd0); end
`ifdef MDU_MADD_EN
      // HI/LO cannot change while busy, so the completion-time value is the accumulator.
      OP_MADD:  begin result = {hi, lo} + prod_s; result_we = 1'b1; end
      OP_MADDU: begin result = {hi, lo} + prod_u; result_we = 1'b1; end
      OP_MSUB:  begin result = {hi, lo} - prod_s; result_we = 1'b1; end
      OP_MSUBU: begin result = {hi, lo} - prod_u; result_we = 1'b1; end
`endif
      default:  begin result = 64'd0; result_we = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi    <= 32'd0;
      lo    <= 32'd0;
      count <= 4'd0;
      op_q  <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
    end else if (accept) begin
      if (op == OP_MTHI) begin
        hi <= rs_val;
      end else if (op == OP_MTLO) begin
        lo <= rs_val;
      end else begin
        op_q  <= op;
        a_q   <= rs_val;
        b_q   <= rt_val;
        count <= is_div ? 4'(DIV_CYCLES) : 4'(MUL_CYCLES);
      end
    end else if (count != 4'd0) begin
      count <= count - 4'd1;
      if (count == 4'd1 && result_we) begin
        hi <= result[63:32];
        lo <= result[31:0];
      end
    end
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and executes mult/multu/div/divu/madd/maddu/msub/msubu/mthi/mtlo.
- Drives the busy/remaining-cycle status that the stall controller consumes to hold D-stage MD instructions.
- It is the responder end of the E-stage start/busy handshake.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu/madd/maddu/msub/msubu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  E-stage MD instruction valid this cycle (the enMDU of the E control word).
- cancel  in  1  exception/interrupt taken this cycle; suppresses start.
- op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu, 9 mthi, 10 mtlo; 11-15 reserved.
- rs_val  in  32  forwarded rs operand.
- rt_val  in  32  forwarded rt operand.
- busy  out  1  operation in flight (count != 0).
- tnew  out  4  remaining busy cycles (count register).
- hi  out  32  HI register (source for mfhi).
- lo  out  32  LO register (source for mflo).

Behaviour:
- Reset: async on rst_n low. hi=0, lo=0, count=0, busy=0, tnew=0, operand/op latches cleared.
- Accept: `accept = start & ~cancel & ~busy & op in 1..10`.
  - start while busy is ignored; the stall controller guarantees this never occurs.
  - Reserved ops are treated as none.
- mthi/mtlo, accepted at edge t: hi (resp. lo) = rs_val from edge t. count stays 0; busy never rises.
- Arithmetic ops, accepted at edge t0:
  - Latch op and operands; load count = MUL_CYCLES or DIV_CYCLES.
  - busy=1 and tnew=count for exactly N cycles after t0.
  - count decrements once per edge.
  - At the edge where count goes 1->0, hi/lo update and busy falls together.
  - hi/lo hold their old values throughout busy.
- Width and rounding rules:
  - mult: {hi,lo} = signed 32x32 -> 64.
  - multu: {hi,lo} = unsigned 32x32 -> 64.
  - madd/maddu: {hi,lo} += product, 64-bit wraparound. The accumulator is the hi/lo value at completion, which equals the value at accept because nothing else can write hi/lo while busy.
  - msub/msubu: {hi,lo} -= product, 64-bit wraparound.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - div special case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (rt_val=0, signed or unsigned): full busy period still occurs; hi/lo unchanged at completion.
- cancel: blocks acceptance only in its own cycle. An operation already in flight always completes (it was committed before the exception).
- Reset mid-operation: count=0 and hi/lo=0 immediately; the pending result is discarded.
- tnew saturates at the loaded value; it never underflows below 0.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: ops 5-8 behave as described above.
- Undefined: ops 5-8 are treated as reserved/none. They are not accepted, busy stays 0 and hi/lo are unchanged, and the accumulate adder/subtractor is not synthesized.

Test Plan:
- Reset, then mult rs=0xFFFFFFFE, rt=3 -> busy high exactly 5 cycles, tnew sequence 5,4,3,2,1,0; final hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles; hi/lo hold prior values during busy.
- div rs=0xFFFFFFF9 (-7), rt=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu rs=7, rt=0 -> busy 10 cycles, hi/lo unchanged.
- mthi rs=0x12345678, then mtlo rs=0x9, then madd rs=2, rt=3 (MDU_MADD_EN defined) -> hi=0x12345678, lo=0xF. Without the macro -> busy stays 0 and lo stays 0x9.
- start=1 with cancel=1 and op=mult -> busy stays 0, hi/lo unchanged. Then start mult during busy of a prior mult -> second request ignored and only the first result is written.
- Drop rst_n at tnew=3 of a div -> busy, tnew, hi and lo all 0 immediately; no late write after rst_n rises.
